// File: rtl/crypt_pkg.sv
// Shared types and round functions for crypt_stream_pipe.
// Round functions work on MAX_N/MAX_SHW wide vectors; callers pass their real widths n and shw.
package crypt_pkg;

    localparam int unsigned MAX_N   = 64;
    localparam int unsigned MAX_SHW = 32;

    typedef enum logic [1:0] {
        ModeEnc    = 2'b00,
        ModeDec    = 2'b01,
        ModeByp    = 2'b10,
        ModeBypAlt = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        DirRotl = 2'b00,
        DirRotr = 2'b01,
        DirAdd  = 2'b10,
        DirXor  = 2'b11
    } dir_e;

    typedef struct packed {
        mode_e              mode;
        dir_e               dir;
        logic [MAX_SHW-1:0] kb;
    } side_t;

    function automatic logic [MAX_N-1:0] width_mask(int unsigned n);
        return {MAX_N{1'b1}} >> (MAX_N - n);
    endfunction

    function automatic logic [MAX_SHW-1:0] key_mask(logic [MAX_SHW-1:0] k, int unsigned shw);
        return k & ({MAX_SHW{1'b1}} >> (MAX_SHW - shw));
    endfunction

    // x must already be confined to n bits and amt < n.
    function automatic logic [MAX_N-1:0] rot_left(logic [MAX_N-1:0] x, int unsigned amt,
                                                  int unsigned n);
        return ((x << amt) | (x >> (n - amt))) & width_mask(n);
    endfunction

    function automatic logic [MAX_N-1:0] rot_right(logic [MAX_N-1:0] x, int unsigned amt,
                                                   int unsigned n);
        return ((x >> amt) | (x << (n - amt))) & width_mask(n);
    endfunction

    function automatic logic [MAX_N-1:0] round_fwd(logic [MAX_N-1:0] x, logic [MAX_SHW-1:0] k,
                                                   dir_e dir, int unsigned n, int unsigned shw);
        logic [MAX_N-1:0]   xm;
        logic [MAX_N-1:0]   kd;
        logic [MAX_SHW-1:0] km;
        int unsigned        amt;
        xm  = x & width_mask(n);
        km  = key_mask(k, shw);
        kd  = MAX_N'(km) & width_mask(n);
        amt = km % n;
        case (dir)
            DirRotl: return rot_left(xm, amt, n);
            DirRotr: return rot_right(xm, amt, n);
            DirAdd:  return (xm + kd) & width_mask(n);
            default: return xm ^ kd;
        endcase
    endfunction

    function automatic logic [MAX_N-1:0] round_inv(logic [MAX_N-1:0] x, logic [MAX_SHW-1:0] k,
                                                   dir_e dir, int unsigned n, int unsigned shw);
        logic [MAX_N-1:0]   xm;
        logic [MAX_N-1:0]   kd;
        logic [MAX_SHW-1:0] km;
        int unsigned        amt;
        xm  = x & width_mask(n);
        km  = key_mask(k, shw);
        kd  = MAX_N'(km) & width_mask(n);
        amt = km % n;
        case (dir)
            DirRotl: return rot_right(xm, amt, n);
            DirRotr: return rot_left(xm, amt, n);
            DirAdd:  return (xm - kd) & width_mask(n);
            default: return xm ^ kd;
        endcase
    endfunction

endpackage

// File: rtl/crypt_round.sv
// One elastic pipeline stage: applies this stage's round to the incoming beat and registers
// data, sideband and valid.
module crypt_round
    import crypt_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned SHW    = 5,
    parameter int unsigned ROUNDS = 2,
    parameter int unsigned IDX    = 0
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  side_t        in_side,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output side_t        out_side
);

    // Decrypt walks the round keys in reverse so stage s undoes encrypt stage ROUNDS-1-s.
    localparam int unsigned DEC_IDX = ROUNDS - 1 - IDX;

    logic               valid_q;
    logic [N-1:0]       data_q;
    logic [N-1:0]       data_d;
    side_t              side_q;
    logic [MAX_SHW-1:0] enc_key;
    logic [MAX_SHW-1:0] dec_key;
    logic [MAX_N-1:0]   x_ext;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        x_ext          = '0;
        x_ext[N-1:0]   = in_data;
        enc_key        = in_side.kb + MAX_SHW'(IDX);
        dec_key        = in_side.kb + MAX_SHW'(DEC_IDX);
        data_d         = in_data;
        case (in_side.mode)
            ModeEnc: data_d = N'(round_fwd(x_ext, enc_key, in_side.dir, N, SHW));
            ModeDec: data_d = N'(round_inv(x_ext, dec_key, in_side.dir, N, SHW));
            default: data_d = in_data;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            side_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= data_d;
                side_q <= in_side;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_side  = side_q;

endmodule

// File: rtl/crypt_stream_pipe.sv
// Pipelined encrypt/decrypt/bypass stream with a rolling per-beat key and valid/ready flow.
// Holds the key register, accepted-beat counter and the ROUNDS-deep stage chain.
module crypt_stream_pipe
    import crypt_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned ROUNDS = 2,
    parameter int unsigned SHW    = 5,
    parameter int unsigned CW     = 16
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic [1:0]     direction,
    input  logic [SHW-1:0] shift,
    input  logic [SHW-1:0] key_step,
    input  logic           key_load,
    input  logic [N-1:0]   din,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   dout,
    output logic [CW-1:0]  count
);

    logic [SHW-1:0] key_q;
    logic [SHW-1:0] kb;
    logic [CW-1:0]  count_q;
    logic           accept;
    side_t          side_in;

    // Element i feeds stage i; element ROUNDS is the pipe output.
    logic           stg_valid [ROUNDS+1];
    logic           stg_ready [ROUNDS+1];
    logic [N-1:0]   stg_data  [ROUNDS+1];
    side_t          stg_side  [ROUNDS+1];
    side_t          unused_tail_side;

    assign kb     = key_load ? shift : key_q;
    assign accept = in_valid && in_ready;

    assign side_in = '{mode: mode_e'(mode), dir: dir_e'(direction), kb: MAX_SHW'(kb)};

    assign stg_valid[0]      = in_valid;
    assign stg_data[0]       = din;
    assign stg_side[0]       = side_in;
    assign in_ready          = stg_ready[0];
    assign stg_ready[ROUNDS] = out_ready;
    assign out_valid         = stg_valid[ROUNDS];
    assign dout              = stg_data[ROUNDS];
    assign unused_tail_side  = stg_side[ROUNDS];

    for (genvar i = 0; i < ROUNDS; i++) begin : g_round
        crypt_round #(
            .N      (N),
            .SHW    (SHW),
            .ROUNDS (ROUNDS),
            .IDX    (i)
        ) u_round (
            .clock     (clock),
            .rst       (rst),
            .in_valid  (stg_valid[i]),
            .in_ready  (stg_ready[i]),
            .in_data   (stg_data[i]),
            .in_side   (stg_side[i]),
            .out_valid (stg_valid[i+1]),
            .out_ready (stg_ready[i+1]),
            .out_data  (stg_data[i+1]),
            .out_side  (stg_side[i+1])
        );
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            count_q <= '0;
        end else if (accept) begin
            key_q   <= kb + key_step;
            count_q <= count_q + CW'(1);
        end else if (key_load) begin
            key_q   <= shift;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_crypt_stream_pipe.sv
// Directed bench for crypt_stream_pipe: single-instance vectors plus an encrypt->decrypt link.
module tb_crypt_stream_pipe;

    logic       clock;
    logic       rst;
    logic       in_valid;
    logic       key_load;
    logic       out_ready;
    logic       chain;
    logic [1:0] mode;
    logic [1:0] direction;
    logic [4:0] shift;
    logic [4:0] key_step;
    logic [7:0] din;

    logic        enc_in_ready, enc_out_valid, enc_out_ready;
    logic [7:0]  enc_dout;
    logic [15:0] enc_count;
    logic        dec_in_valid, dec_in_ready, dec_out_valid;
    logic [7:0]  dec_dout;
    logic [15:0] dec_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    assign enc_out_ready = chain ? dec_in_ready : out_ready;
    assign dec_in_valid  = chain && enc_out_valid;

    crypt_stream_pipe u_enc (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (enc_in_ready),
        .mode      (mode),
        .direction (direction),
        .shift     (shift),
        .key_step  (key_step),
        .key_load  (key_load),
        .din       (din),
        .out_valid (enc_out_valid),
        .out_ready (enc_out_ready),
        .dout      (enc_dout),
        .count     (enc_count)
    );

    crypt_stream_pipe u_dec (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (dec_in_valid),
        .in_ready  (dec_in_ready),
        .mode      (2'b01),
        .direction (direction),
        .shift     (shift),
        .key_step  (key_step),
        .key_load  (key_load),
        .din       (enc_dout),
        .out_valid (dec_out_valid),
        .out_ready (out_ready),
        .dout      (dec_dout),
        .count     (dec_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        key_load  = 1'b0;
        key_step  = '0;
        chain     = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        rst = 1'b0;
    endtask

    // One beat, no preceding reset; expects dout after the second edge and count 1.
    task automatic beat_core(input string tag, input logic [7:0] d, input logic [1:0] m,
                             input logic [1:0] dr, input logic [4:0] sh, input logic ld,
                             input logic [7:0] exp);
        out_ready = 1'b1;
        mode      = m;
        direction = dr;
        shift     = sh;
        key_load  = ld;
        din       = d;
        in_valid  = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        key_load = 1'b0;
        check({tag, "_lat"}, enc_out_valid, 0);
        @(negedge clock);
        check({tag, "_valid"}, enc_out_valid, 1);
        check(tag, enc_dout, exp);
        check({tag, "_cnt"}, enc_count, 1);
        @(negedge clock);
        check({tag, "_drain"}, enc_out_valid, 0);
    endtask

    task automatic single_beat(input string tag, input logic [7:0] d, input logic [1:0] m,
                               input logic [1:0] dr, input logic [4:0] sh, input logic [7:0] exp);
        do_reset();
        beat_core(tag, d, m, dr, sh, 1'b1, exp);
    endtask

    // Two back-to-back beats; the first reloads the key from sh.
    task automatic pair_beats(input string tag, input logic [4:0] step, input logic [4:0] sh,
                              input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] dr,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] exp0, input logic [7:0] exp1);
        do_reset();
        key_step  = step;
        direction = dr;
        mode      = m0;
        shift     = sh;
        key_load  = 1'b1;
        din       = d0;
        in_valid  = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        mode     = m1;
        din      = d1;
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, "_v0"}, enc_out_valid, 1);
        check({tag, "_d0"}, enc_dout, exp0);
        @(negedge clock);
        check({tag, "_v1"}, enc_out_valid, 1);
        check({tag, "_d1"}, enc_dout, exp1);
        check({tag, "_cnt"}, enc_count, 2);
        key_step = '0;
    endtask

    initial begin
        int         sent;
        logic [7:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        key_load  = 1'b0;
        key_step  = '0;
        chain     = 1'b0;
        out_ready = 1'b1;
        mode      = '0;
        direction = '0;
        shift     = '0;
        din       = '0;
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        check("rst_out_valid", enc_out_valid, 0);
        check("rst_in_ready", enc_in_ready, 1);
        check("rst_dout", enc_dout, 0);
        check("rst_count", enc_count, 0);

        single_beat("enc_rotl", 8'h81, 2'b00, 2'b00, 5'd3, 8'hC0);
        single_beat("dec_rotl", 8'hC0, 2'b01, 2'b00, 5'd3, 8'h81);
        single_beat("enc_rotr", 8'h81, 2'b00, 2'b01, 5'd1, 8'h30);
        single_beat("enc_add", 8'hFE, 2'b00, 2'b10, 5'd5, 8'h09);
        single_beat("dec_add", 8'h09, 2'b01, 2'b10, 5'd5, 8'hFE);
        single_beat("key_wrap", 8'h00, 2'b00, 2'b10, 5'd31, 8'h1F);
        single_beat("rot_modn", 8'h81, 2'b00, 2'b00, 5'd8, 8'h03);
        single_beat("bypass", 8'h5A, 2'b10, 2'b11, 5'd7, 8'h5A);
        single_beat("bypass3", 8'hA5, 2'b11, 2'b00, 5'd2, 8'hA5);

        pair_beats("load_step", 5'd2, 5'd4, 2'b00, 2'b00, 2'b10, 8'h00, 8'h00, 8'h09, 8'h0D);
        pair_beats("byp_key", 5'd3, 5'd0, 2'b10, 2'b00, 2'b11, 8'h5A, 8'h00, 8'h5A, 8'h07);

        // Rolling xor key over three back-to-back zero beats.
        do_reset();
        key_step  = 5'd1;
        mode      = 2'b00;
        direction = 2'b11;
        shift     = 5'd0;
        key_load  = 1'b1;
        din       = 8'h00;
        in_valid  = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        @(negedge clock);
        check("roll_d0", enc_dout, 8'h01);
        check("roll_v0", enc_out_valid, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check("roll_d1", enc_dout, 8'h03);
        @(negedge clock);
        check("roll_d2", enc_dout, 8'h01);
        check("roll_cnt", enc_count, 3);
        @(negedge clock);
        check("roll_drain", enc_out_valid, 0);
        key_step = '0;

        // Backpressure on one instance: dout = din ^ 0 ^ 1.
        do_reset();
        mode      = 2'b00;
        direction = 2'b11;
        shift     = 5'd0;
        q.delete();
        sent = 0;
        held = '0;
        for (int c = 0; c < 80 && q.size() < 8; c++) begin
            in_valid  = (sent < 8);
            din       = 8'h10 + 8'(sent);
            key_load  = (sent == 0);
            out_ready = (c >= 4);
            #1;
            if (c == 1) check("bp_ready_c1", enc_in_ready, 1);
            if (c == 2) begin
                check("bp_ready_c2", enc_in_ready, 0);
                check("bp_hold_valid", enc_out_valid, 1);
                held = enc_dout;
            end
            if (c == 3) begin
                check("bp_ready_c3", enc_in_ready, 0);
                check("bp_stable_valid", enc_out_valid, 1);
                check("bp_stable_dout", enc_dout, held);
            end
            if (enc_out_valid && enc_out_ready) q.push_back(enc_dout);
            if (in_valid && enc_in_ready) sent++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        key_load = 1'b0;
        check("bp_count_out", q.size(), 8);
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            check($sformatf("bp_out%0d", i), q[i], (8'h10 + 8'(i)) ^ 8'h01);
        end
        check("bp_cnt", enc_count, 8);

        // Encrypt -> decrypt link under backpressure recovers the plaintext.
        do_reset();
        chain     = 1'b1;
        mode      = 2'b00;
        direction = 2'b00;
        shift     = 5'd3;
        key_load  = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        q.delete();
        sent = 0;
        for (int c = 0; c < 100 && q.size() < 8; c++) begin
            in_valid  = (sent < 8);
            din       = 8'h10 + 8'(sent);
            out_ready = (c >= 4);
            #1;
            if (dec_out_valid && out_ready) q.push_back(dec_dout);
            if (in_valid && enc_in_ready) sent++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("link_count_out", q.size(), 8);
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            check($sformatf("link_out%0d", i), q[i], 8'h10 + 8'(i));
        end
        check("link_dec_cnt", dec_count, 8);
        chain = 1'b0;

        // Asynchronous reset with two beats in flight.
        do_reset();
        mode      = 2'b00;
        direction = 2'b00;
        shift     = 5'd5;
        key_load  = 1'b1;
        din       = 8'h81;
        in_valid  = 1'b1;
        @(negedge clock);
        key_load = 1'b0;
        din      = 8'h42;
        @(negedge clock);
        in_valid = 1'b0;
        check("mid_pre_valid", enc_out_valid, 1);
        check("mid_pre_cnt", enc_count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid", enc_out_valid, 0);
        check("mid_dout", enc_dout, 0);
        check("mid_cnt", enc_count, 0);
        check("mid_ready", enc_in_ready, 1);
        @(negedge clock);
        rst = 1'b0;
        beat_core("post_rst", 8'h81, 2'b00, 2'b00, 5'd0, 1'b0, 8'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crypt_stream_pipe.md
# crypt_stream_pipe

Parametrised, fully pipelined successor to the fixed 8-bit encrypt/decrypt pair. One instance performs either encryption, decryption or bypass per beat, over `ROUNDS` registered rounds, with valid/ready flow control and a rolling per-beat key. It sits between a byte/word source and sink. Two instances (encrypt side, decrypt side) loaded with identical key settings form a matched link.

## Interface
- `N`, 8: data width, N ≥ 2
- `ROUNDS`, 2: number of round stages, which is also the latency, ≥ 1
- `SHW`, 5: key/shift width
- `CW`, 16: accepted-beat counter width

Ports:
- `clock`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `mode`  in  2  00 encrypt, 01 decrypt, 1x bypass; sampled with the beat
- `direction`  in  2  00 rotate-left, 01 rotate-right, 10 add, 11 xor; sampled with the beat
- `shift`  in  SHW  base key, loaded by `key_load`
- `key_step`  in  SHW  key increment per accepted beat
- `key_load`  in  1  reload key register from `shift`
- `din`  in  N  input data
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  sink ready
- `dout`  out  N  output data
- `count`  out  CW  accepted input beats, wraps modulo 2^CW

## Operation
- **Beat key.** `kb = key_load ? shift : key_reg`.
- **Key register update on accept.** `key_reg <= kb + key_step` (mod 2^SHW).
- **Key register update on `key_load` without accept.** `key_reg <= shift`.
- **Round key.** `k_r = kb + r` (mod 2^SHW), for r = 0..ROUNDS-1.
- **Forward round with key k:**
  - rotl by `k mod N`
  - rotr by `k mod N`
  - `x + k` (mod 2^N, k zero-extended or truncated to N bits)
  - `x ^ k` (same extension)
- **Inverse round.** Exact inverse of the forward round: rotr, rotl, subtract, xor respectively.
- **Encrypt.** Stage s applies forward round with `k_s`, s = 0..ROUNDS-1.
- **Decrypt.** Stage s applies the inverse round with `k_(ROUNDS-1-s)`.
- **Round-trip guarantee.** decrypt(encrypt(x)) == x for equal `kb` and `direction`.
- **Bypass.** Data is unchanged, latency is unchanged, and the key still advances.
- **Sideband.** `mode`, `direction` and `kb` travel down the pipe with the data. A mid-stream change affects only newly accepted beats.
- **Pipeline.** Elastic; each stage holds data, sideband and a valid bit.
  - A stage loads when it is empty or when its downstream stage moves.
  - `in_ready = !v[0] || stage0 moves`, where stage0 moves when stage 1 can accept (combinational ready chain, no bubble).
  - `out_valid = v[ROUNDS-1]`; `dout` is that stage's data.
- **Counter.** `count` increments on each accept and wraps to 0.

## Timing
- **Reset values.** `out_valid` 0, `in_ready` 1 after reset, `dout` 0, `count` 0, `key_reg` 0, all stage valids 0.
- **Latency.** A beat accepted at edge t appears on `dout` with `out_valid` after edge t+ROUNDS-1, and is consumed at edge t+ROUNDS when `out_ready` is high.
- **Throughput.** 1 beat per clock while `out_ready` is held high.
- **Backpressure.** With `out_ready` low, the pipe fills to ROUNDS beats, then `in_ready` falls in the same cycle. No beat is dropped, duplicated or reordered.
- **Output stability.** `dout` and `out_valid` are stable while `out_valid && !out_ready`.
- **Simultaneous load and accept.** `key_load` with an accepted beat: the beat uses `shift`, and `key_reg` becomes `shift + key_step`.
- **Key wrap.** The key wraps modulo 2^SHW.
- **Rotation amount.** The rotation amount is taken modulo N. An amount of 0 or N yields the identity.
- **Reset mid-stream.** `rst` asserted mid-stream discards all in-flight beats immediately (asynchronous). Outputs return to their reset values.

## Structure
- **Package `crypt_pkg`:**
  - `mode_e`
  - `dir_e`
  - functions `round_fwd(x, k, dir)` and `round_inv(x, k, dir)`, parametrised through the module's N, SHW via a class-free width convention
  - stage sideband struct {mode, dir, kb}
- **Sub-module `crypt_round`.** One registered pipeline stage: data, sideband, valid, local stage index, ready in/out. Instantiated ROUNDS times with generate.
- **Top.** Holds key register, counter and input sideband capture.

## Test plan
(N=8, ROUNDS=2, SHW=5, `key_step`=0 unless stated)
- **Encrypt, rotate-left.** `key_load` with `shift`=3, encrypt rotl, `din`=0x81 -> `dout`=0xC0 two cycles later (rotl3 gives 0x0C, then rotl4 gives 0xC0).
- **Decrypt, rotate-right.** `shift`=3, decrypt rotl, `din`=0xC0 -> `dout`=0x81.
- **Add with wrap.** `shift`=5, encrypt add, `din`=0xFE -> 0x03 after round 0, `dout`=0x09.
- **Rolling xor key.** `shift`=0, `key_step`=1, xor, three back-to-back beats of 0x00 -> `dout` 0x01, 0x03, 0x01; `count`=3.
- **Backpressure.** Continuous `in_valid` with beats 0x10..0x17, `out_ready` low for 4 cycles -> `in_ready` low after 2 beats held. All 8 outputs arrive in order with none lost; an encrypt instance feeding a decrypt instance returns 0x10..0x17.
- **Reset mid-stream.** `rst` pulsed with 2 beats in flight -> `out_valid` 0 without a clock edge. `count` and `key_reg` are 0, and the next beat with `shift`=0 rotl gives `dout`=`din` rotl 1.
